axi_rd_arbiter: RTL and testbench

//   Read-channel arbiter/scheduler between CPU_wrapper masters M0 (IF) and M1 (MEM) and one slave read port (IM/DM side).

---
 rtl/axi_rd_arbiter.sv | 128 ++++++++++++
 tb/tb_axi_rd_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_rd_arbiter.sv
// Two-master AXI read arbiter, one outstanding read: AR forwarded 1 cycle after grant, R beats routed with 0-cycle latency.
// R backpressure comes straight from the granted master; define ARB_ROUND_ROBIN_EN for round-robin, else fixed M0 priority.
module axi_rd_arbiter #(
  parameter int IDW = 4,
  parameter int AW  = 32,
  parameter int DW  = 32,
  parameter int LW  = 4,
  parameter int SW  = 3,
  localparam int PW  = IDW + AW + LW + SW + 2,
  localparam int RSW = IDW + 1 + DW + 3,
  localparam int RMW = IDW + DW + 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [PW-1:0]  ARPAY_M0,
  input  logic           ARVALID_M0,
  output logic           ARREADY_M0,
  input  logic [PW-1:0]  ARPAY_M1,
  input  logic           ARVALID_M1,
  output logic           ARREADY_M1,
  output logic [PW:0]    ARPAY_S,
  output logic           ARVALID_S,
  input  logic           ARREADY_S,
  input  logic [RSW-1:0] RPAY_S,
  input  logic           RVALID_S,
  output logic           RREADY_S,
  output logic [RMW-1:0] RPAY_M,
  output logic           RVALID_M0,
  input  logic           RREADY_M0,
  output logic           RVALID_M1,
  input  logic           RREADY_M1,
  output logic           RERR
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t      state;
  logic        grant;
  logic [LW:0] beat_cnt;
`ifdef ARB_ROUND_ROBIN_EN
  logic        last_grant;
`endif

  logic          any_req;
  logic          win;
  logic          take;
  logic          in_data;
  logic          beat;
  logic          r_last;
  logic          r_gnt;
  logic [LW:0]   len_ext;
  logic          err_now;

  assign any_req = ARVALID_M0 | ARVALID_M1;

`ifdef ARB_ROUND_ROBIN_EN
  assign win = (ARVALID_M0 & ARVALID_M1) ? ~last_grant : ARVALID_M1;
`else
  assign win = ~ARVALID_M0;
`endif

  // Handshake and routing are gated by rst so every output drops the moment reset asserts.
  assign take       = rst & (state == IDLE) & any_req;
  assign ARREADY_M0 = take & ~win;
  assign ARREADY_M1 = take & win;

  assign in_data   = rst & (state == DATA);
  assign RVALID_M0 = in_data & ~grant & RVALID_S;
  assign RVALID_M1 = in_data & grant & RVALID_S;
  assign RREADY_S  = in_data & (grant ? RREADY_M1 : RREADY_M0);
  assign RPAY_M    = in_data ? RPAY_S[RMW-1:0] : '0;

  assign beat    = RVALID_S & RREADY_S;
  assign r_last  = RPAY_S[0];
  assign r_gnt   = RPAY_S[RSW-1];
  assign len_ext = {1'b0, ARPAY_S[SW+2 +: LW]};

  // Beat index must hit ARLEN exactly on RLAST, and the echoed grant bit must match.
  assign err_now = (r_last && (beat_cnt != len_ext))
                || (!r_last && (beat_cnt == len_ext))
                || (r_gnt != grant);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      grant     <= 1'b0;
      beat_cnt  <= '0;
      RERR      <= 1'b0;
      ARVALID_S <= 1'b0;
      ARPAY_S   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            grant     <= win;
            ARPAY_S   <= {win, (win ? ARPAY_M1 : ARPAY_M0)};
            ARVALID_S <= 1'b1;
            state     <= ADDR;
          end
        end
        ADDR: begin
          if (ARREADY_S) begin
            ARVALID_S <= 1'b0;
            beat_cnt  <= '0;
            state     <= DATA;
          end
        end
        DATA: begin
          if (beat) begin
            if (beat_cnt != '1) beat_cnt <= beat_cnt + 1'b1;
            if (err_now) RERR <= 1'b1;
            if (r_last) begin
              state <= IDLE;
`ifdef ARB_ROUND_ROBIN_EN
              last_grant <= grant;
`endif
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter: grant order, AR hold, R routing/backpressure, RERR, async reset.
module tb_axi_rd_arbiter;
  localparam int IDW = 4, AW = 32, DW = 32, LW = 4, SW = 3;
  localparam int PW  = IDW + AW + LW + SW + 2;
  localparam int RSW = IDW + 1 + DW + 3;
  localparam int RMW = IDW + DW + 3;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [PW-1:0]  ARPAY_M0 = '0, ARPAY_M1 = '0;
  logic           ARVALID_M0 = 1'b0, ARVALID_M1 = 1'b0;
  logic           ARREADY_M0, ARREADY_M1;
  logic [PW:0]    ARPAY_S;
  logic           ARVALID_S;
  logic           ARREADY_S = 1'b0;
  logic [RSW-1:0] RPAY_S = '0;
  logic           RVALID_S = 1'b0;
  logic           RREADY_S;
  logic [RMW-1:0] RPAY_M;
  logic           RVALID_M0, RVALID_M1;
  logic           RREADY_M0 = 1'b0, RREADY_M1 = 1'b0;
  logic           RERR;

  int checks = 0;
  int errors = 0;
  logic [PW:0] exp_pay;
  logic        g2;

  always #5 clk = ~clk;

  axi_rd_arbiter #(.IDW(IDW), .AW(AW), .DW(DW), .LW(LW), .SW(SW)) dut (
    .clk(clk), .rst(rst),
    .ARPAY_M0(ARPAY_M0), .ARVALID_M0(ARVALID_M0), .ARREADY_M0(ARREADY_M0),
    .ARPAY_M1(ARPAY_M1), .ARVALID_M1(ARVALID_M1), .ARREADY_M1(ARREADY_M1),
    .ARPAY_S(ARPAY_S), .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RPAY_S(RPAY_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .RPAY_M(RPAY_M), .RVALID_M0(RVALID_M0), .RREADY_M0(RREADY_M0),
    .RVALID_M1(RVALID_M1), .RREADY_M1(RREADY_M1), .RERR(RERR)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] mk(input logic [3:0] id, input logic [31:0] a, input logic [3:0] len);
    return {id, a, len, 3'd2, 2'b01};
  endfunction

  // Raise requests, check the winner, cross the grant edge, check the registered slave AR.
  task automatic req(input logic v0, input logic v1, input logic g, input string tag);
    ARVALID_M0 = v0;
    ARVALID_M1 = v1;
    #1;
    chk({tag, ".arready_m0"}, 64'(ARREADY_M0), 64'(!g));
    chk({tag, ".arready_m1"}, 64'(ARREADY_M1), 64'(g));
    exp_pay = {g, (g ? ARPAY_M1 : ARPAY_M0)};
    step();
    chk({tag, ".arvalid_s"}, 64'(ARVALID_S), 64'd1);
    chk({tag, ".arpay_s"}, 64'(ARPAY_S), 64'(exp_pay));
    chk({tag, ".addr_no_ready"}, 64'({ARREADY_M0, ARREADY_M1}), 64'd0);
  endtask

  task automatic addr_go(input string tag);
    ARREADY_S = 1'b1;
    #1;
    chk({tag, ".arvalid_hold"}, 64'(ARVALID_S), 64'd1);
    step();
    ARREADY_S = 1'b0;
    #1;
    chk({tag, ".arvalid_drop"}, 64'(ARVALID_S), 64'd0);
  endtask

  task automatic beat(input logic g, input logic [3:0] id, input logic [31:0] d, input logic last, input string tag);
    RPAY_S    = {g, id, d, 2'b00, last};
    RVALID_S  = 1'b1;
    RREADY_M0 = 1'b1;
    RREADY_M1 = 1'b1;
    #1;
    chk({tag, ".rvalid_m"}, 64'({RVALID_M1, RVALID_M0}), 64'(g ? 2'b10 : 2'b01));
    chk({tag, ".rready_s"}, 64'(RREADY_S), 64'd1);
    chk({tag, ".rpay_m"}, 64'(RPAY_M), 64'({id, d, 2'b00, last}));
    step();
    RVALID_S = 1'b0;
  endtask

  initial begin
    #50000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1, "bench timeout");
  end

  initial begin
    // Reset state, including requests held during reset
    #3;
    chk("rst.outs", 64'({ARREADY_M0, ARREADY_M1, ARVALID_S, RREADY_S, RVALID_M0, RVALID_M1, RERR}), 64'd0);
    chk("rst.arpay_s", 64'(ARPAY_S), 64'd0);
    chk("rst.rpay_m", 64'(RPAY_M), 64'd0);
    ARVALID_M0 = 1'b1;
    #1;
    chk("rst.arready_gated", 64'(ARREADY_M0), 64'd0);
    ARVALID_M0 = 1'b0;
    #3 rst = 1'b1;
    step();

    // 1: M0 LEN=3, four beats
    ARPAY_M0 = mk(4'h2, 32'h0000_0100, 4'd3);
    req(1'b1, 1'b0, 1'b0, "t1");
    ARVALID_M0 = 1'b0;
    addr_go("t1");
    for (int i = 0; i < 4; i++) beat(1'b0, 4'h2, 32'hA000_0000 + 32'(i), (i == 3), "t1.beat");
    chk("t1.rerr", 64'(RERR), 64'd0);
    RVALID_S = 1'b1;
    RREADY_M0 = 1'b1;
    #1;
    chk("t1.idle_rready_s", 64'(RREADY_S), 64'd0);
    chk("t1.idle_rvalid_m0", 64'(RVALID_M0), 64'd0);
    RVALID_S = 1'b0;

    // 2: simultaneous requests right after a reset, two rounds
    #2 rst = 1'b0;
    #2 rst = 1'b1;
    step();
    ARPAY_M0 = mk(4'h3, 32'h0000_0300, 4'd0);
    ARPAY_M1 = mk(4'h4, 32'h0000_0400, 4'd0);
    req(1'b1, 1'b1, 1'b0, "t2a");
    addr_go("t2a");
    beat(1'b0, 4'h3, 32'h3333_0000, 1'b1, "t2a.beat");
`ifdef ARB_ROUND_ROBIN_EN
    g2 = 1'b1;
`else
    g2 = 1'b0;
`endif
    req(1'b1, 1'b1, g2, "t2b");
    addr_go("t2b");
    beat(g2, (g2 ? 4'h4 : 4'h3), 32'h3333_0001, 1'b1, "t2b.beat");
    ARVALID_M0 = 1'b0;
    ARVALID_M1 = 1'b0;

    // 3: slave stalls AR for 5 cycles; payload stays registered
    ARPAY_M1 = mk(4'h1, 32'h0000_2000, 4'd0);
    req(1'b0, 1'b1, 1'b1, "t3");
    ARVALID_M1 = 1'b0;
    ARPAY_M1 = mk(4'h7, 32'hDEAD_BEEF, 4'd5);
    for (int i = 0; i < 5; i++) begin
      chk("t3.stall_arvalid", 64'(ARVALID_S), 64'd1);
      chk("t3.stall_arpay", 64'(ARPAY_S), 64'(exp_pay));
      chk("t3.stall_id", 64'(ARPAY_S[PW -: 5]), 64'h11);
      step();
    end
    addr_go("t3");
    beat(1'b1, 4'h1, 32'h0000_0333, 1'b1, "t3.beat");
    chk("t3.rerr", 64'(RERR), 64'd0);

    // 4: M1 stalls R for 3 cycles mid-burst
    ARPAY_M1 = mk(4'h5, 32'h0000_3000, 4'd3);
    req(1'b0, 1'b1, 1'b1, "t4");
    ARVALID_M1 = 1'b0;
    addr_go("t4");
    beat(1'b1, 4'h5, 32'h4444_0000, 1'b0, "t4.b0");
    beat(1'b1, 4'h5, 32'h4444_0001, 1'b0, "t4.b1");
    RPAY_S = {1'b1, 4'h5, 32'h4444_0002, 2'b00, 1'b0};
    RVALID_S = 1'b1;
    RREADY_M0 = 1'b1;
    RREADY_M1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("t4.stall_rready_s", 64'(RREADY_S), 64'd0);
      chk("t4.stall_rvalid_m1", 64'(RVALID_M1), 64'd1);
      step();
    end
    beat(1'b1, 4'h5, 32'h4444_0002, 1'b0, "t4.b2");
    beat(1'b1, 4'h5, 32'h4444_0003, 1'b1, "t4.b3");
    chk("t4.rerr", 64'(RERR), 64'd0);

    // 5: LEN=1 but RLAST on beat 0 -> sticky error, next transaction still served
    ARPAY_M0 = mk(4'h6, 32'h0000_0500, 4'd1);
    req(1'b1, 1'b0, 1'b0, "t5");
    ARVALID_M0 = 1'b0;
    addr_go("t5");
    beat(1'b0, 4'h6, 32'h5555_0000, 1'b1, "t5.beat");
    chk("t5.rerr_set", 64'(RERR), 64'd1);
    ARPAY_M1 = mk(4'h2, 32'h0000_0600, 4'd0);
    req(1'b0, 1'b1, 1'b1, "t5n");
    ARVALID_M1 = 1'b0;
    addr_go("t5n");
    beat(1'b1, 4'h2, 32'h5555_0001, 1'b1, "t5n.beat");
    chk("t5.rerr_sticky", 64'(RERR), 64'd1);

    // 6: async reset during beat 2, then fresh M1 request
    ARPAY_M0 = mk(4'h8, 32'h0000_0700, 4'd3);
    req(1'b1, 1'b0, 1'b0, "t6");
    ARVALID_M0 = 1'b0;
    addr_go("t6");
    beat(1'b0, 4'h8, 32'h6666_0000, 1'b0, "t6.b0");
    beat(1'b0, 4'h8, 32'h6666_0001, 1'b0, "t6.b1");
    RPAY_S = {1'b0, 4'h8, 32'h6666_0002, 2'b00, 1'b0};
    RVALID_S = 1'b1;
    ARVALID_M1 = 1'b1;
    ARPAY_M1 = mk(4'h9, 32'h0000_0800, 4'd0);
    #1;
    chk("t6.pre_rvalid_m0", 64'(RVALID_M0), 64'd1);
    #1 rst = 1'b0;
    #1;
    chk("t6.rst_outs", 64'({ARREADY_M0, ARREADY_M1, ARVALID_S, RREADY_S, RVALID_M0, RVALID_M1, RERR}), 64'd0);
    chk("t6.rst_rpay_m", 64'(RPAY_M), 64'd0);
    chk("t6.rst_arpay_s", 64'(ARPAY_S), 64'd0);
    #3 rst = 1'b1;
    RVALID_S = 1'b0;
    req(1'b0, 1'b1, 1'b1, "t6n");
    ARVALID_M1 = 1'b0;
    addr_go("t6n");
    beat(1'b1, 4'h9, 32'h6666_0003, 1'b1, "t6n.beat");
    chk("t6.rerr", 64'(RERR), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
